// File: rtl/adxl345_sample_sequencer.sv
// ADXL345 sample sequencer: configures the part once, then reads X/Y/Z every SAMPLE_DIV cycles.
// Latency: read bursts start exactly SAMPLE_DIV clk apart; sample_valid_o is raised the cycle after the 6th data byte.
// Backpressure: stalls per byte until spi_done_i arrives; aborts the frame after TIMEOUT cycles without a done.
// Ports: clk_i/reset_i (async, active-high); enable_i run request;
//        spi_start_o/spi_tx_byte_o/spi_cs_n_o drive the SPI byte engine, spi_done_i/spi_rx_byte_i return from it;
//        x/y/z_data_o with sample_valid_o strobe; configured_o status; timeout_err_o sticky error.
module adxl345_sample_sequencer #(
   parameter int unsigned SAMPLE_DIV = 100000,
   parameter logic [7:0]  FORMAT_VAL = 8'h08,
   parameter logic [7:0]  POWER_VAL  = 8'h08,
   parameter int unsigned TIMEOUT    = 4096
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   output logic        spi_start_o,
   output logic [7:0]  spi_tx_byte_o,
   output logic        spi_cs_n_o,
   input  logic        spi_done_i,
   input  logic [7:0]  spi_rx_byte_i,
   output logic [15:0] x_data_o,
   output logic [15:0] y_data_o,
   output logic [15:0] z_data_o,
   output logic        sample_valid_o,
   output logic        configured_o,
   output logic        timeout_err_o
);
   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, CFG_ADDR, CFG_DATA, CS_GAP, WAIT_DIV, RD_CMD, RD_BYTE, PUBLISH
   } state_t;

   state_t           state_q;
   logic             cfg_idx_q;      // 0: DATA_FORMAT, 1: POWER_CTL
   logic [2:0]       byte_cnt_q;     // data byte index in RD_BYTE, gap cycle count in CS_GAP
   logic [DIV_W-1:0] div_cnt_q;
   logic [TO_W-1:0]  to_cnt_q;
   logic             wait_q;         // start issued for current byte, awaiting spi_done
   logic             first_q;        // first burst after configuration goes out immediately
   logic [7:0]       shadow_q [5];   // bytes 0..4; byte 5 goes straight from spi_rx_byte_i

   logic             spi_start_q;
   logic [7:0]       spi_tx_byte_q;
   logic             cs_n_q;
   logic [15:0]      x_q, y_q, z_q;
   logic             valid_q;
   logic             configured_q;
   logic             err_q;

   logic [7:0]       tx_byte_d;
   logic [DIV_W-1:0] div_cnt_d;

   always_comb begin
      tx_byte_d = 8'h00;
      case (state_q)
         CFG_ADDR: tx_byte_d = cfg_idx_q ? 8'h2D : 8'h31;
         CFG_DATA: tx_byte_d = cfg_idx_q ? POWER_VAL : FORMAT_VAL;
         RD_CMD:   tx_byte_d = 8'hF2;   // read, multibyte, start at DATAX0 (0x32)
         default:  tx_byte_d = 8'h00;
      endcase
   end

   // Saturate so a long idle never wraps the divider into a late burst.
   assign div_cnt_d = (div_cnt_q == DIV_LAST) ? div_cnt_q : div_cnt_q + DIV_W'(1);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= IDLE;
         cfg_idx_q     <= 1'b0;
         byte_cnt_q    <= 3'd0;
         div_cnt_q     <= '0;
         to_cnt_q      <= '0;
         wait_q        <= 1'b0;
         first_q       <= 1'b0;
         for (int i = 0; i < 5; i++) shadow_q[i] <= 8'h00;
         spi_start_q   <= 1'b0;
         spi_tx_byte_q <= 8'h00;
         cs_n_q        <= 1'b1;
         x_q           <= 16'h0000;
         y_q           <= 16'h0000;
         z_q           <= 16'h0000;
         valid_q       <= 1'b0;
         configured_q  <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         spi_start_q <= 1'b0;
         valid_q     <= 1'b0;
         // Divider free-runs across the whole burst so the burst period is exact.
         if (state_q != IDLE) div_cnt_q <= div_cnt_d;
         if (wait_q) to_cnt_q <= to_cnt_q + TO_W'(1);

         case (state_q)
            IDLE: begin
               if (enable_i) begin
                  if (configured_q) begin
                     state_q <= WAIT_DIV;
                  end else begin
                     state_q   <= CFG_ADDR;
                     cfg_idx_q <= 1'b0;
                     cs_n_q    <= 1'b0;
                  end
               end
            end

            CFG_ADDR, CFG_DATA, RD_CMD, RD_BYTE: begin
               if (!wait_q) begin
                  // One start per byte; tx byte then held until the done.
                  spi_start_q   <= 1'b1;
                  spi_tx_byte_q <= tx_byte_d;
                  wait_q        <= 1'b1;
                  to_cnt_q      <= '0;
               end else if (spi_done_i) begin
                  wait_q <= 1'b0;
                  case (state_q)
                     CFG_ADDR: state_q <= CFG_DATA;
                     CFG_DATA: begin
                        state_q    <= CS_GAP;
                        cs_n_q     <= 1'b1;
                        byte_cnt_q <= 3'd0;
                     end
                     RD_CMD: begin
                        state_q    <= RD_BYTE;
                        byte_cnt_q <= 3'd0;
                     end
                     default: begin
                        if (byte_cnt_q == 3'd5) begin
                           x_q     <= {shadow_q[1], shadow_q[0]};
                           y_q     <= {shadow_q[3], shadow_q[2]};
                           z_q     <= {spi_rx_byte_i, shadow_q[4]};
                           valid_q <= 1'b1;
                           cs_n_q  <= 1'b1;
                           state_q <= PUBLISH;
                        end else begin
                           shadow_q[byte_cnt_q] <= spi_rx_byte_i;
                           byte_cnt_q           <= byte_cnt_q + 3'd1;
                        end
                     end
                  endcase
               end else if (to_cnt_q == TO_LAST) begin
                  // Engine hung: drop the frame and force a fresh configuration.
                  wait_q       <= 1'b0;
                  cs_n_q       <= 1'b1;
                  err_q        <= 1'b1;
                  configured_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end

            CS_GAP: begin
               if (byte_cnt_q == 3'd1) begin
                  if (!cfg_idx_q) begin
                     state_q   <= CFG_ADDR;
                     cfg_idx_q <= 1'b1;
                     cs_n_q    <= 1'b0;
                  end else begin
                     configured_q <= 1'b1;
                     first_q      <= 1'b1;
                     state_q      <= enable_i ? WAIT_DIV : IDLE;
                  end
               end else begin
                  byte_cnt_q <= byte_cnt_q + 3'd1;
               end
            end

            WAIT_DIV: begin
               if (!enable_i) begin
                  state_q <= IDLE;
               end else if (first_q || div_cnt_q >= DIV_LAST) begin
                  state_q   <= RD_CMD;
                  cs_n_q    <= 1'b0;
                  div_cnt_q <= '0;
                  first_q   <= 1'b0;
               end
            end

            PUBLISH: state_q <= enable_i ? WAIT_DIV : IDLE;

            default: state_q <= IDLE;
         endcase
      end
   end

   assign spi_start_o    = spi_start_q;
   assign spi_tx_byte_o  = spi_tx_byte_q;
   assign spi_cs_n_o     = cs_n_q;
   assign x_data_o       = x_q;
   assign y_data_o       = y_q;
   assign z_data_o       = z_q;
   assign sample_valid_o = valid_q;
   assign configured_o   = configured_q;
   assign timeout_err_o  = err_q;

endmodule

// File: tb/tb_adxl345_sample_sequencer.sv
// Bench for adxl345_sample_sequencer: SPI engine model answering each start 8 cycles later,
// random burst data checked against expected little-endian X/Y/Z words and MOSI byte stream.
// Directed phases: reset, config, periodic bursts, enable drop, done timeout, mid-burst reset.
`define CHK(TAG, OBS, EXP) begin tests_run++; assert ((OBS) === (EXP)) else begin tests_failed++; $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); end end

module tb_adxl345_sample_sequencer;
   localparam int SDIV = 200;
   localparam int TOUT = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        spi_done = 1'b0;
   logic [7:0]  spi_rx = 8'h00;
   logic        spi_start;
   logic [7:0]  spi_tx_byte;
   logic        spi_cs_n;
   logic [15:0] x_data, y_data, z_data;
   logic        sample_valid, configured, timeout_err;

   adxl345_sample_sequencer #(
      .SAMPLE_DIV(SDIV), .FORMAT_VAL(8'h08), .POWER_VAL(8'h08), .TIMEOUT(TOUT)
   ) dut (
      .clk_i(clk), .reset_i(reset), .enable_i(enable),
      .spi_start_o(spi_start), .spi_tx_byte_o(spi_tx_byte), .spi_cs_n_o(spi_cs_n),
      .spi_done_i(spi_done), .spi_rx_byte_i(spi_rx),
      .x_data_o(x_data), .y_data_o(y_data), .z_data_o(z_data),
      .sample_valid_o(sample_valid), .configured_o(configured), .timeout_err_o(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int tests_run = 0;
   int tests_failed = 0;

   // Engine model / monitor state
   int          eng_cnt = 0;
   logic [7:0]  pend_tx = 8'h00, pend_rx = 8'h00;
   bit          pend_data = 0;
   bit          withhold = 0;
   int          n_done = 0, rd_done = 0, sv_count = 0;
   logic        cfg_at_4th = 1'bx;
   int          start_while_busy = 0, tx_unstable = 0, dbl_valid = 0, silent_change = 0;
   int          cs_run = 0;
   bit          prev_valid = 0, prev_err = 0;
   int          err_cyc = -1;
   logic        cs_at_err = 1'bx, cfg_at_err = 1'bx;
   logic [15:0] last_x = 0, last_y = 0, last_z = 0;
   logic [7:0]  tx_log[$], rx_q[$], exp_tx[$];
   int          f2_times[$], gaps[$];
   logic [15:0] act_x[$], act_y[$], act_z[$], exp_x[$], exp_y[$], exp_z[$];

   always @(negedge clk) begin
      spi_done = 1'b0;
      if (reset) begin
         eng_cnt = 0; rd_done = 0; cs_run = 0; prev_valid = 0; prev_err = 0;
         last_x = 0; last_y = 0; last_z = 0;
         rx_q.delete();
      end else begin
         if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               spi_done = 1'b1;
               spi_rx   = pend_rx;
               n_done++;
               if (pend_data) rd_done++;
               if (n_done == 4) cfg_at_4th = configured;
            end
         end
         if (eng_cnt > 0 && spi_start) start_while_busy++;
         if (eng_cnt > 0 && spi_tx_byte !== pend_tx) tx_unstable++;
         if (spi_start) begin
            tx_log.push_back(spi_tx_byte);
            pend_tx = spi_tx_byte;
            if (spi_tx_byte == 8'hF2) begin
               f2_times.push_back(cyc);
               rd_done = 0;
            end
            if (spi_tx_byte == 8'h00) begin
               pend_data = 1;
               pend_rx = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hA5;
            end else begin
               pend_data = 0;
               pend_rx = 8'($urandom);
            end
            if (!(withhold && spi_tx_byte == 8'hF2)) eng_cnt = 8;
         end
         if (sample_valid) begin
            act_x.push_back(x_data); act_y.push_back(y_data); act_z.push_back(z_data);
            sv_count++;
            if (prev_valid) dbl_valid++;
         end else if (x_data !== last_x || y_data !== last_y || z_data !== last_z) begin
            silent_change++;
         end
         prev_valid = sample_valid;
         last_x = x_data; last_y = y_data; last_z = z_data;
         if (timeout_err && !prev_err) begin
            err_cyc = cyc; cs_at_err = spi_cs_n; cfg_at_err = configured;
         end
         prev_err = timeout_err;
         if (spi_cs_n) cs_run++;
         else begin
            if (cs_run > 0) gaps.push_back(cs_run);
            cs_run = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Queue one burst of 6 data bytes (b[7:0] first on the wire) and its expected result.
   task automatic push_burst(input logic [47:0] b, input bit expect_it);
      for (int i = 0; i < 6; i++) rx_q.push_back(b[8*i +: 8]);
      if (expect_it) begin
         exp_x.push_back(b[15:0]);
         exp_y.push_back(b[31:16]);
         exp_z.push_back(b[47:32]);
         exp_tx.push_back(8'hF2);
         repeat (6) exp_tx.push_back(8'h00);
      end
   endtask

   function automatic logic [47:0] rand_bytes();
      logic [47:0] r;
      r[31:0]  = $urandom;
      r[47:32] = 16'($urandom);
      return r;
   endfunction

   task automatic check_sample(input string tag);
      logic [15:0] ax, ay, az, ex, ey, ez;
      `CHK({tag, "_avail"}, (act_x.size() > 0 && exp_x.size() > 0), 1'b1)
      if (act_x.size() > 0 && exp_x.size() > 0) begin
         ax = act_x.pop_front(); ay = act_y.pop_front(); az = act_z.pop_front();
         ex = exp_x.pop_front(); ey = exp_y.pop_front(); ez = exp_z.pop_front();
         `CHK({tag, "_x"}, ax, ex)
         `CHK({tag, "_y"}, ay, ey)
         `CHK({tag, "_z"}, az, ez)
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      `CHK({tag, "_start"}, spi_start, 1'b0)
      `CHK({tag, "_tx"}, spi_tx_byte, 8'h00)
      `CHK({tag, "_cs_n"}, spi_cs_n, 1'b1)
      `CHK({tag, "_x"}, x_data, 16'h0000)
      `CHK({tag, "_y"}, y_data, 16'h0000)
      `CHK({tag, "_z"}, z_data, 16'h0000)
      `CHK({tag, "_valid"}, sample_valid, 1'b0)
      `CHK({tag, "_configured"}, configured, 1'b0)
      `CHK({tag, "_timeout_err"}, timeout_err, 1'b0)
   endtask

   initial begin
      int n0, ntx, ts, g1, g2, mism, svb;

      // Reset state
      repeat (3) tick();
      check_reset_outputs("rst");

      // Configuration then the directed first burst
      exp_tx.push_back(8'h31); exp_tx.push_back(8'h08);
      exp_tx.push_back(8'h2D); exp_tx.push_back(8'h08);
      push_burst(48'h01_00_FF_F0_01_10, 1);
      reset  = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 600 && sv_count < 1; i++) tick();
      `CHK("cfg_first_sample_cnt", sv_count, 1)
      `CHK("cfg_not_done_at_4th_done", cfg_at_4th, 1'b0)
      `CHK("cfg_configured", configured, 1'b1)
      g1 = (gaps.size() > 1) ? gaps[1] : -1;
      g2 = (gaps.size() > 2) ? gaps[2] : -1;
      `CHK("cfg_cs_gap_between_writes", g1, 2)
      `CHK("cfg_cs_gap_before_read", (g2 >= 2), 1'b1)
      `CHK("burst1_x", x_data, 16'h0110)
      `CHK("burst1_y", y_data, 16'hFFF0)
      `CHK("burst1_z", z_data, 16'h0100)
      check_sample("burst1");

      // Periodic random bursts
      for (int k = 0; k < 4; k++) push_burst(rand_bytes(), 1);
      for (int i = 0; i < 1200 && sv_count < 5; i++) tick();
      `CHK("period_sample_cnt", sv_count, 5)
      for (int k = 0; k < 4; k++) check_sample("period");
      `CHK("period_f2_cnt", (f2_times.size() >= 5), 1'b1)
      for (int k = 1; k < 5 && k < f2_times.size(); k++)
         `CHK("period_f2_spacing", f2_times[k] - f2_times[k-1], SDIV)

      // Enable dropped after the third data byte
      push_burst(rand_bytes(), 1);
      n0 = f2_times.size();
      for (int i = 0; i < 400 && f2_times.size() <= n0; i++) tick();
      for (int i = 0; i < 100 && rd_done < 3; i++) tick();
      `CHK("drop_third_byte_seen", rd_done, 3)
      enable = 1'b0;
      for (int i = 0; i < 200 && sv_count < 6; i++) tick();
      `CHK("drop_sample_cnt", sv_count, 6)
      check_sample("drop");
      repeat (3) tick();
      `CHK("drop_cs_n", spi_cs_n, 1'b1)
      ntx = tx_log.size();
      repeat (300) tick();
      `CHK("drop_idle_no_starts", tx_log.size(), ntx)
      `CHK("drop_idle_no_sample", sv_count, 6)
      `CHK("drop_configured_kept", configured, 1'b1)

      // Re-enable resumes reads without reconfiguration
      push_burst(rand_bytes(), 1);
      enable = 1'b1;
      for (int i = 0; i < 600 && sv_count < 7; i++) tick();
      `CHK("reen_sample_cnt", sv_count, 7)
      check_sample("reen");
      `CHK("reen_first_byte_f2", (tx_log.size() > ntx) ? tx_log[ntx] : 8'hxx, 8'hF2)

      // Done withheld after the read command
      withhold = 1;
      err_cyc  = -1;
      n0 = f2_times.size();
      for (int i = 0; i < 400 && f2_times.size() <= n0; i++) tick();
      ts = (f2_times.size() > n0) ? f2_times[f2_times.size()-1] : 0;
      for (int i = 0; i < TOUT + 50 && err_cyc < 0; i++) tick();
      `CHK("to_latency", err_cyc - ts, TOUT)
      `CHK("to_cs_n", cs_at_err, 1'b1)
      `CHK("to_configured_cleared", cfg_at_err, 1'b0)
      `CHK("to_err_flag", timeout_err, 1'b1)
      `CHK("to_no_sample", sv_count, 7)
      withhold = 0;
      exp_tx.push_back(8'hF2);
      exp_tx.push_back(8'h31); exp_tx.push_back(8'h08);
      exp_tx.push_back(8'h2D); exp_tx.push_back(8'h08);
      push_burst(rand_bytes(), 1);
      for (int i = 0; i < 600 && sv_count < 8; i++) tick();
      `CHK("to_recover_sample_cnt", sv_count, 8)
      check_sample("to_recover");
      `CHK("to_recover_configured", configured, 1'b1)
      `CHK("to_err_sticky", timeout_err, 1'b1)

      // Whole MOSI stream and protocol invariants so far
      `CHK("mosi_len", tx_log.size(), exp_tx.size())
      mism = 0;
      for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
         if (tx_log[i] !== exp_tx[i]) mism++;
      `CHK("mosi_bytes", mism, 0)
      `CHK("start_while_busy", start_while_busy, 0)
      `CHK("tx_byte_stable", tx_unstable, 0)
      `CHK("valid_single_cycle", dbl_valid, 0)
      `CHK("outputs_quiet_mid_burst", silent_change, 0)

      // Reset in the middle of the data bytes
      push_burst(rand_bytes(), 0);
      n0 = f2_times.size();
      for (int i = 0; i < 400 && f2_times.size() <= n0; i++) tick();
      for (int i = 0; i < 100 && rd_done < 2; i++) tick();
      `CHK("mid_rst_in_burst", rd_done, 2)
      svb = sv_count;
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      enable = 1'b0;
      repeat (10) tick();
      `CHK("mid_rst_no_strobe", sv_count, svb)
      `CHK("mid_rst_x_hold", x_data, 16'h0000)
      reset = 1'b0;
      repeat (20) tick();
      `CHK("post_rst_cs_n", spi_cs_n, 1'b1)
      `CHK("post_rst_no_strobe", sv_count, svb)
      `CHK("post_rst_configured", configured, 1'b0)
      `CHK("post_rst_err", timeout_err, 1'b0)

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
